// File: rtl/pll.sv
// Integer clock divider with 50% duty and a sticky lock flag.
// All state is on clk_in; clr clears everything asynchronously.
module pll #(
    parameter int DIV         = 2,
    parameter int LOCK_CYCLES = 4
) (
    input  logic clk_in,
    output logic clk_out,
    input  logic clr = 1'b0,
    output logic locked
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    if (DIV < 1) begin : g_div_check
        $error("pll: DIV must be >= 1");
    end
    if (LOCK_CYCLES < 1) begin : g_lock_check
        $error("pll: LOCK_CYCLES must be >= 1");
    end

    // Two-flop reset synchroniser; run is high from the release posedge onward.
    logic rst_meta;
    logic rst_sync;
    logic run;
    logic rise;

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    assign run = ~rst_sync;

    if (DIV == 1) begin : g_div1
        // Enable is retimed on the falling edge so the AND gate never chops a high phase.
        logic en_n;

        always_ff @(negedge clk_in or posedge clr) begin
            if (clr) begin
                en_n <= 1'b0;
            end else begin
                en_n <= run;
            end
        end

        assign clk_out = clk_in & en_n;
        assign rise    = run;
    end else begin : g_divn
        logic [CW-1:0] cnt;

        always_ff @(posedge clk_in or posedge clr) begin
            if (clr) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
            end
        end

        assign rise = run && (cnt == '0);

        if (DIV % 2 == 0) begin : g_even
            logic q;

            always_ff @(posedge clk_in or posedge clr) begin
                if (clr) begin
                    q <= 1'b0;
                end else begin
                    q <= run && (cnt < CW'(DIV / 2));
                end
            end

            assign clk_out = q;
        end else begin : g_odd
            // p covers the whole input periods of the high phase; n extends it by
            // the trailing half period. Only one of them changes at any instant.
            logic p;
            logic n;

            always_ff @(posedge clk_in or posedge clr) begin
                if (clr) begin
                    p <= 1'b0;
                end else begin
                    p <= run && (cnt < CW'((DIV - 1) / 2));
                end
            end

            always_ff @(negedge clk_in or posedge clr) begin
                if (clr) begin
                    n <= 1'b0;
                end else begin
                    n <= p;
                end
            end

            assign clk_out = p | n;
        end
    end

    // Counts clk_out rising edges; locked latches on the LOCK_CYCLES-th one.
    logic [LW-1:0] lock_cnt;

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (rise && !locked) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll.sv
// Bench for pll: DIV=2, DIV=3 and DIV=1 instances share clk_in/clr; every
// clk_out and locked transition is timed against an expected queue.
module tb_pll;

    localparam int WIN_END = 302;

    logic       clk_in;
    logic       clr;
    logic [2:0] co;
    logic [2:0] lk;

    pll #(.DIV(2), .LOCK_CYCLES(4)) u_div2 (
        .clk_in (clk_in),
        .clk_out(co[0]),
        .clr    (clr),
        .locked (lk[0])
    );

    pll #(.DIV(3), .LOCK_CYCLES(3)) u_div3 (
        .clk_in (clk_in),
        .clk_out(co[1]),
        .clr    (clr),
        .locked (lk[1])
    );

    pll #(.DIV(1), .LOCK_CYCLES(4)) u_div1 (
        .clk_in (clk_in),
        .clk_out(co[2]),
        .clr    (clr),
        .locked (lk[2])
    );

    // clock/reset: posedges at 5, 15, 25, ...
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Scoreboard: entry = {level, time}. Index 2*i is clk_out of DUT i, 2*i+1 its locked.
    logic [32:0] exp_q [6][$];
    string       names [6];
    int          n_cmp;
    int          n_err;
    logic [2:0]  prev_co;
    logic [2:0]  prev_lk;

    task automatic check_val(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int k, input logic v);
        logic [32:0] act;
        logic [32:0] exp;
        act = {v, 32'($time)};
        n_cmp++;
        if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected: got level %b at t=%0t, required no transition",
                     names[k], v, $time);
        end else begin
            exp = exp_q[k].pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s: got level %b at t=%0d, required level %b at t=%0d",
                         names[k], act[32], act[31:0], exp[32], exp[31:0]);
            end
        end
    endtask

    // Expected clk_out edges: rise every d input periods from rel, fall d half-periods later.
    task automatic push_edges(input int k, input int rel, input int d, input int t_end);
        for (int t = rel; t <= t_end; t += d * 10) begin
            exp_q[k].push_back({1'b1, 32'(t)});
            if (t + d * 5 <= t_end) begin
                exp_q[k].push_back({1'b0, 32'(t + d * 5)});
            end
        end
    endtask

    // monitor
    always @(co or lk) begin
        if ($time > 0 && $time <= WIN_END) begin
            for (int i = 0; i < 3; i++) begin
                if (co[i] !== prev_co[i]) pop_check(2 * i, co[i]);
                if (lk[i] !== prev_lk[i]) pop_check(2 * i + 1, lk[i]);
            end
        end
        prev_co = co;
        prev_lk = lk;
    end

    // driver
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        names[0] = "div2_clk_out";
        names[1] = "div2_locked";
        names[2] = "div3_clk_out";
        names[3] = "div3_locked";
        names[4] = "div1_clk_out";
        names[5] = "div1_locked";
        clr      = 1'b1;

        #3;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset_clk_out%0d", i), co[i], 1'b0);
            check_val($sformatf("reset_locked%0d", i), lk[i], 1'b0);
        end

        // Release at t=12: sync low after posedge 25, release posedge is 35.
        #9;
        push_edges(0, 35, 2, 137);
        push_edges(2, 35, 3, 137);
        push_edges(4, 35, 1, 137);
        exp_q[1].push_back({1'b1, 32'd95});
        exp_q[3].push_back({1'b1, 32'd95});
        exp_q[5].push_back({1'b1, 32'd65});
        clr = 1'b0;

        // t=138: every clk_out is mid-high; clr must drop it and locked immediately.
        #126;
        for (int i = 0; i < 3; i++) begin
            exp_q[2 * i].push_back({1'b0, 32'd138});
            exp_q[2 * i + 1].push_back({1'b0, 32'd138});
        end
        clr = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("midclr_clk_out%0d", i), co[i], 1'b0);
            check_val($sformatf("midclr_locked%0d", i), lk[i], 1'b0);
        end

        // Release at t=152: release posedge is 175, lock counting restarts.
        #13;
        push_edges(0, 175, 2, WIN_END);
        push_edges(2, 175, 3, WIN_END);
        push_edges(4, 175, 1, WIN_END);
        exp_q[1].push_back({1'b1, 32'd235});
        exp_q[3].push_back({1'b1, 32'd235});
        exp_q[5].push_back({1'b1, 32'd205});
        clr = 1'b0;

        #151;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (exp_q[k].size() != 0) begin
                n_err++;
                $display("FAIL %s missing: got %0d pending transitions, required 0 (next at t=%0d)",
                         names[k], exp_q[k].size(), exp_q[k][0][31:0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
